// File: rtl/sd_buffer_pkg.sv
// sd_buffer_pkg: shared widths, pace defaults and reader FSM encoding
// for the read side of the 16-bit CDC buffer.
package sd_buffer_pkg;

  localparam int DATA_W    = 16;
  localparam int PROG_W    = 3;
  localparam int HOLD_BASE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    CAPT = 2'd2,
    HOLD = 2'd3
  } rd_state_t;

  // bits needed to hold the longest interval minus one
  function automatic int cnt_width(input int base, input int pw);
    int w;
    w = $clog2(base << ((1 << pw) - 1));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rd_pace_counter.sv
// rd_pace_counter: hold-interval down counter for buffer_reader.
// Loads (HOLD_BASE << prog_reg) - 1 and counts down to a zero flag.
module rd_pace_counter #(
  parameter int HOLD_BASE = sd_buffer_pkg::HOLD_BASE,
  parameter int PROG_W    = sd_buffer_pkg::PROG_W,
  parameter int CNT_W     = sd_buffer_pkg::cnt_width(HOLD_BASE, PROG_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [PROG_W-1:0] prog_reg,
  output logic              zero
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] span;

  // span wraps to 0 at the widest shift; minus one still gives all ones
  assign span = CNT_W'(HOLD_BASE) << prog_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= span - CNT_W'(1);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/buffer_reader.sv
// buffer_reader: paced pop/hold controller for the CDC buffer read side.
// Define BUFFER_READER_PARITY_EN to build the registered parity output.
module buffer_reader #(
  parameter int DATA_W    = sd_buffer_pkg::DATA_W,
  parameter int HOLD_BASE = sd_buffer_pkg::HOLD_BASE,
  parameter int PROG_W    = sd_buffer_pkg::PROG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              flush,
  input  logic              update,
  input  logic [PROG_W-1:0] prog,
  input  logic              buffer_empty,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity,
  output logic              drained
);

  import sd_buffer_pkg::*;

  rd_state_t         state;
  rd_state_t         state_nx;
  logic              flush_pend;
  logic [PROG_W-1:0] prog_reg;
  logic              cnt_load;
  logic              cnt_zero;
  logic              go;

  assign go = (enable | flush_pend) & ~buffer_empty;

  rd_pace_counter #(
    .HOLD_BASE (HOLD_BASE),
    .PROG_W    (PROG_W)
  ) u_pace (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .prog_reg (prog_reg),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) state_nx = POP;
      end
      POP: begin
        state_nx = CAPT;
      end
      CAPT: begin
        if (flush_pend & ~buffer_empty) begin
          state_nx = POP;
        end else begin
          state_nx = HOLD;
          cnt_load = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_zero | flush_pend) state_nx = go ? POP : IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
      prog_reg   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      data_valid <= (state == CAPT);
      if (update) prog_reg <= prog;
      if (state == CAPT) data_out <= rd_data;
      // a new flush request wins over the drain-complete clear
      if (flush) begin
        flush_pend <= 1'b1;
      end else if ((state == IDLE) & buffer_empty) begin
        flush_pend <= 1'b0;
      end
    end
  end

`ifdef BUFFER_READER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity <= 1'b0;
    end else if (state == CAPT) begin
      parity <= ^rd_data;
    end
  end
`else
  assign parity = 1'b0;
`endif

  assign rd_en   = (state == POP);
  assign drained = (state == IDLE) & buffer_empty & ~flush_pend;

endmodule

// File: tb/tb_buffer_reader.sv
// tb_buffer_reader: random and directed stimulus for buffer_reader,
// checked every cycle against a timestamp-based reference model.
module tb_buffer_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic        update = 1'b0;
  logic [2:0]  prog = '0;
  logic        buffer_empty;
  logic [15:0] rd_data = '0;
  logic        rd_en;
  logic [15:0] data_out;
  logic        data_valid;
  logic        parity;
  logic        drained;

  buffer_reader dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .flush        (flush),
    .update       (update),
    .prog         (prog),
    .buffer_empty (buffer_empty),
    .rd_data      (rd_data),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .parity       (parity),
    .drained      (drained)
  );

  always #5 clk = ~clk;

  // buffer: data appears on rd_data one cycle after rd_en
  logic [15:0] mem [1024];
  int rd_ptr = 0;
  int wr_ptr = 0;
  assign buffer_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (rd_en && !buffer_empty) begin
      rd_data <= mem[rd_ptr % 1024];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  int          dv_t [$];
  logic [15:0] dv_d [$];
  bit          dv_p [$];
  int          re_t [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr % 1024] = w;
    wr_ptr++;
  endtask

  // reference model: schedules pop, capture and hold-end as cycle numbers
  int          m_pop = -1;
  int          m_capt = -1;
  int          m_hold = -1;
  bit          m_idle = 1'b1;
  bit          m_fp = 1'b0;
  bit          m_dv = 1'b0;
  int          m_preg = 0;
  logic [15:0] m_dout = '0;

  initial forever begin
    bit emp;
    bit fp0;
    bit idle0;
    @(posedge clk);
    if (rst) begin
      m_pop = -1; m_capt = -1; m_hold = -1;
      m_idle = 1'b1; m_fp = 1'b0; m_dv = 1'b0;
      m_preg = 0; m_dout = '0;
    end else begin
      emp = buffer_empty;
      fp0 = m_fp;
      idle0 = m_idle;
      m_dv = 1'b0;
      if (cyc == m_pop) begin
        m_capt = cyc + 1;
      end else if (cyc == m_capt) begin
        m_dout = rd_data;
        m_dv = 1'b1;
        if (fp0 && !emp) m_pop = cyc + 1;
        else m_hold = cyc + (4 << m_preg);
      end else if (m_idle || cyc >= m_hold || fp0) begin
        if ((enable || fp0) && !emp) begin
          m_pop = cyc + 1;
          m_idle = 1'b0;
        end else begin
          m_idle = 1'b1;
        end
      end
      if (flush) m_fp = 1'b1;
      else if (idle0 && emp) m_fp = 1'b0;
      if (update) m_preg = int'(prog);
    end
    cyc = cyc + 1;
  end

  initial forever begin
    bit exp_par;
    @(posedge clk);
    #1;
    if (chk_on) begin
`ifdef BUFFER_READER_PARITY_EN
      exp_par = ^m_dout;
`else
      exp_par = 1'b0;
`endif
      chk("rd_en", 32'(rd_en), 32'(m_pop == cyc));
      chk("data_out", 32'(data_out), 32'(m_dout));
      chk("data_valid", 32'(data_valid), 32'(m_dv));
      chk("parity", 32'(parity), 32'(exp_par));
      chk("drained", 32'(drained), 32'(m_idle && buffer_empty && !m_fp));
      if (rd_en) chk("pop_on_empty", 32'(buffer_empty), 32'd0);
      if (data_valid) begin
        dv_t.push_back(cyc);
        dv_d.push_back(data_out);
        dv_p.push_back(parity);
      end
      if (rd_en) re_t.push_back(cyc);
    end
  end

  task automatic clear_logs();
    dv_t.delete(); dv_d.delete(); dv_p.delete(); re_t.delete();
  endtask

  task automatic wait_dv(input int n, input int budget);
    int k = 0;
    while (dv_t.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("dv_count", 32'(dv_t.size()), 32'(n));
  endtask

  task automatic wait_drained(input int budget, output int t);
    int k = 0;
    while (!drained && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain_wait", 32'(drained), 32'd1);
    t = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  logic [15:0] t2w [3];
  int t;
  int k;

  initial begin
    t2w[0] = 16'h0001;
    t2w[1] = 16'h0003;
    t2w[2] = 16'h8000;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_drained", 32'(drained), 32'd1);
    rst = 1'b0;

    // empty buffer with enable held high
    clear_logs();
    enable = 1'b1;
    repeat (100) @(negedge clk);
    chk("t1_pops", 32'(re_t.size()), 32'd0);
    chk("t1_drained", 32'(drained), 32'd1);
    chk("t1_dout", 32'(data_out), 32'd0);
    enable = 1'b0;

    // three words at prog_reg 0
    for (int i = 0; i < 3; i++) push(t2w[i]);
    clear_logs();
    enable = 1'b1;
    wait_dv(3, 200);
    if (dv_t.size() >= 3) begin
      for (int i = 0; i < 3; i++) chk("t2_data", 32'(dv_d[i]), 32'(t2w[i]));
      chk("t2_gap0", 32'(dv_t[1] - dv_t[0]), 32'd6);
      chk("t2_gap1", 32'(dv_t[2] - dv_t[1]), 32'd6);
`ifdef BUFFER_READER_PARITY_EN
      chk("t2_par0", 32'(dv_p[0]), 32'd1);
      chk("t2_par1", 32'(dv_p[1]), 32'd0);
      chk("t2_par2", 32'(dv_p[2]), 32'd1);
`else
      chk("t2_par0", 32'(dv_p[0]), 32'd0);
`endif
      wait_drained(100, t);
      chk("t2_drain_lat", 32'(t - dv_t[2]), 32'd4);
    end

    // pace change during the first hold
    clear_logs();
    for (int i = 0; i < 4; i++) push(16'h1000 + 16'(i * 3 + 1));
    wait_dv(1, 50);
    update = 1'b1;
    prog = 3'd2;
    @(negedge clk);
    update = 1'b0;
    wait_dv(4, 300);
    if (dv_t.size() >= 4) begin
      chk("t3_gap0", 32'(dv_t[1] - dv_t[0]), 32'd6);
      chk("t3_gap1", 32'(dv_t[2] - dv_t[1]), 32'd18);
      chk("t3_gap2", 32'(dv_t[3] - dv_t[2]), 32'd18);
    end
    wait_drained(100, t);

    // flush with enable low; update in the same cycle
    enable = 1'b0;
    for (int i = 0; i < 5; i++) push(16'hA5A0 + 16'(i));
    clear_logs();
    repeat (2) @(negedge clk);
    chk("t4_pre_drained", 32'(drained), 32'd0);
    flush = 1'b1;
    update = 1'b1;
    prog = 3'd0;
    @(negedge clk);
    flush = 1'b0;
    update = 1'b0;
    wait_dv(5, 100);
    wait_drained(100, t);
    chk("t4_pops", 32'(re_t.size()), 32'd5);
    if (re_t.size() >= 5 && dv_t.size() >= 5) begin
      for (int i = 0; i < 4; i++)
        chk("t4_pop_gap", 32'(re_t[i + 1] - re_t[i]), 32'd2);
      chk("t4_drain_lat", 32'(t - dv_t[4]), 32'd2);
    end

    // reset during CAPT
    push(16'h7E01);
    push(16'h7E02);
    clear_logs();
    enable = 1'b1;
    k = 0;
    while (re_t.size() < 1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t5_pop_seen", 32'(re_t.size()), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("t5_rd_en", 32'(rd_en), 32'd0);
    chk("t5_dout", 32'(data_out), 32'd0);
    chk("t5_dv", 32'(data_valid), 32'd0);
    chk("t5_par", 32'(parity), 32'd0);
    chk("t5_drained", 32'(drained), 32'(buffer_empty));
    @(negedge clk);
    rst = 1'b0;
    wait_drained(100, t);

    // enable dropped during hold, words left behind
    update = 1'b1;
    prog = 3'd2;
    @(negedge clk);
    update = 1'b0;
    for (int i = 0; i < 3; i++) push(16'h3C00 + 16'(i));
    clear_logs();
    wait_dv(1, 50);
    enable = 1'b0;
    repeat (40) @(negedge clk);
    chk("t6_pops", 32'(re_t.size()), 32'd1);
    chk("t6_drained", 32'(drained), 32'd0);
    chk("t6_left", 32'(wr_ptr - rd_ptr), 32'd2);
    enable = 1'b1;
    wait_drained(200, t);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      enable = ($urandom_range(3) != 0);
      flush  = ($urandom_range(39) == 0);
      update = ($urandom_range(24) == 0);
      prog   = ($urandom_range(9) == 0) ? 3'($urandom_range(7, 4))
                                        : 3'($urandom_range(3));
      rst    = ($urandom_range(299) == 0);
      if ($urandom_range(2) == 0 && wr_ptr - rd_ptr < 64)
        push(16'($urandom));
    end
    @(negedge clk);
    rst = 1'b0;
    update = 1'b0;
    enable = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_drained(2000, t);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
